// File: rtl/lm_sm_sequencer.sv
// ----------------------------------------------------------------------------
// lm_sm_sequencer: expands LM/SM register masks into single-register micro-ops
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lm_sm_sequencer #(
  parameter int          NREG   = 8,
  parameter logic [3:0]  OPC_LM = 4'b0110,
  parameter logic [3:0]  OPC_SM = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_valid,
  input  logic [15:0] ir,
  input  logic [15:0] base_data,
  input  logic        stall_in,
  input  logic        flush,
  output logic        freeze_fetch,
  output logic        busy,
  output logic        uop_valid,
  output logic        uop_load,
  output logic [2:0]  uop_reg,
  output logic [15:0] uop_addr,
  output logic        uop_first,
  output logic        uop_last,
  output logic        seq_done
);

  localparam int OW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [NREG-1:0] mask_q;
  logic [15:0]     base_q;
  logic [OW-1:0]   offset_q;
  logic            is_load_q;

  logic            start;
  logic            accept;
  logic            last_bit;
  logic [NREG-1:0] mask_clr;
  logic [2:0]      low_idx;
  logic [3:0]      opcode;

  assign opcode   = ir[15:12];
  assign mask_clr = mask_q & (mask_q - 1'b1);
  assign last_bit = (mask_q != '0) && (mask_clr == '0);
  assign accept   = (state == SEQ) && !stall_in;

  // rst_n qualifies start so freeze_fetch drops the moment reset is asserted
  assign start = rst_n && (state == IDLE) && ir_valid && !flush &&
                 ((opcode == OPC_LM) || (opcode == OPC_SM)) &&
                 (ir[NREG-1:0] != '0);

  always_comb begin
    low_idx = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      base_q    <= '0;
      offset_q  <= '0;
      is_load_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        mask_q <= '0;
      end else if (start) begin
        mask_q    <= ir[NREG-1:0];
        base_q    <= base_data;
        is_load_q <= (opcode == OPC_LM);
        offset_q  <= '0;
      end else if (accept) begin
        mask_q   <= mask_clr;
        offset_q <= offset_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    freeze_fetch = 1'b0;
    busy         = 1'b0;
    uop_valid    = 1'b0;
    uop_load     = 1'b0;
    uop_reg      = 3'd0;
    uop_addr     = 16'd0;
    uop_first    = 1'b0;
    uop_last     = 1'b0;
    seq_done     = 1'b0;
    case (state)
      IDLE: begin
        freeze_fetch = start;
        if (start) state_nxt = SEQ;
      end
      SEQ: begin
        busy         = 1'b1;
        uop_valid    = 1'b1;
        uop_load     = is_load_q;
        uop_reg      = low_idx;
        uop_addr     = base_q + 16'(offset_q);
        uop_first    = (offset_q == '0);
        uop_last     = last_bit;
        seq_done     = accept && last_bit && !flush;
        freeze_fetch = !flush && !(accept && last_bit);
        if (flush || (accept && last_bit)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
